// File: rtl/ame_sched_pkg.sv
// Shared types and operand index constants for the AME numerator scheduler.
// Operand set is {M, D, L, C}, packed with M in the top slot.
package ame_sched_pkg;

  localparam int COMP_DATA_BITS_DEF = 64;
  localparam int NUM_REQ_DEF        = 4;

  localparam int M_IDX = 3;
  localparam int D_IDX = 2;
  localparam int L_IDX = 1;
  localparam int C_IDX = 0;

  typedef logic [3:0][COMP_DATA_BITS_DEF-1:0] ame_operands_t;

  typedef struct packed {
    logic                           v;
    logic [$clog2(NUM_REQ_DEF)-1:0] id;
  } ame_tag_t;

endpackage

// File: rtl/ame_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
// Zero latency; grant_vld low when no request is pending.
module ame_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IDW-1:0]     grant_idx,
  output logic               grant_vld
);

  localparam logic [IDW:0] NREQ = NUM_REQ[IDW:0];

  logic [IDW:0] idx;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + k[IDW:0];
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_vld && req[idx[IDW-1:0]]) begin
        grant_vld                = 1'b1;
        grant_idx                = idx[IDW-1:0];
        grant_oh[idx[IDW-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ame_num_sched.sv
// Round-robin share of one M*D-L*C compute unit; handshake to response is COMP_LATENCY+2 cycles.
// Backpressure only via pause_i/arbitration on req_ready_o; responses cannot be stalled.
module ame_num_sched
  import ame_sched_pkg::*;
#(
  parameter int COMP_DATA_BITS = COMP_DATA_BITS_DEF,
  parameter int NUM_REQ        = NUM_REQ_DEF,
  parameter int COMP_LATENCY   = 1
) (
  input  logic                                        clk_i,
  input  logic                                        rst_n_i,
  input  logic                                        pause_i,
  input  logic [NUM_REQ-1:0]                          req_valid_i,
  output logic [NUM_REQ-1:0]                          req_ready_o,
  input  logic [NUM_REQ-1:0][3:0][COMP_DATA_BITS-1:0] req_data_i,
  output logic [NUM_REQ-1:0]                          rsp_valid_o,
  output logic [COMP_DATA_BITS-1:0]                   rsp_data_o,
  output logic                                        comp_init_o,
  output logic [3:0][COMP_DATA_BITS-1:0]              comp_data_o,
  input  logic                                        comp_done_i,
  input  logic [COMP_DATA_BITS-1:0]                   comp_data_i,
  output logic                                        busy_o,
  output logic                                        err_o
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_REQ - 1);

  typedef struct packed {
    logic           v;
    logic [IDW-1:0] id;
  } tag_t;

  logic [IDW-1:0]     ptr;
  logic [NUM_REQ-1:0] grant_oh;
  logic [IDW-1:0]     grant_idx;
  logic               grant_vld;
  logic               fire;
  tag_t               issue_tag;
  tag_t               tag_pipe [COMP_LATENCY];
  tag_t               tag_out;

  ame_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid_i),
    .ptr       (ptr),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign req_ready_o = (!pause_i && grant_vld) ? grant_oh : '0;
  assign fire        = |(req_valid_i & req_ready_o);
  assign tag_out     = tag_pipe[COMP_LATENCY-1];

  // issue_tag travels alongside comp_init_o; the pipe then covers the unit latency
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr         <= '0;
      comp_init_o <= 1'b0;
      comp_data_o <= '0;
      issue_tag   <= '0;
      for (int k = 0; k < COMP_LATENCY; k++) tag_pipe[k] <= '0;
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
      err_o       <= 1'b0;
    end else begin
      if (fire) ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
      comp_init_o  <= fire;
      comp_data_o  <= fire ? req_data_i[grant_idx] : '0;
      issue_tag.v  <= fire;
      issue_tag.id <= fire ? grant_idx : '0;
      tag_pipe[0]  <= issue_tag;
      for (int k = 1; k < COMP_LATENCY; k++) tag_pipe[k] <= tag_pipe[k-1];
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
      if (tag_out.v && comp_done_i) begin
        rsp_valid_o[tag_out.id] <= 1'b1;
        rsp_data_o              <= comp_data_i;
      end
      // unexpected or missing done: flag and drop the slot
      if (tag_out.v != comp_done_i) err_o <= 1'b1;
    end
  end

  always_comb begin
    busy_o = comp_init_o | issue_tag.v | (|rsp_valid_o);
    for (int k = 0; k < COMP_LATENCY; k++) busy_o = busy_o | tag_pipe[k].v;
  end

endmodule

// File: tb/tb_ame_num_sched.sv
// Bench for ame_num_sched: directed table plus random traffic against a queue-based model.
module tb_ame_num_sched;
  import ame_sched_pkg::*;

  localparam int W  = 64;
  localparam int N  = 4;
  localparam int CL = 1;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     pause = 1'b0;
  logic [N-1:0]             req_valid = '0;
  logic [N-1:0]             req_ready;
  logic [N-1:0][3:0][W-1:0] req_data = '0;
  logic [N-1:0]             rsp_valid;
  logic [W-1:0]             rsp_data;
  logic                     comp_init;
  logic [3:0][W-1:0]        comp_data;
  logic                     comp_done;
  logic [W-1:0]             comp_rdat;
  logic                     busy;
  logic                     err;
  logic                     inj_done = 1'b0;

  always #5 clk = ~clk;

  ame_num_sched #(.COMP_DATA_BITS(W), .NUM_REQ(N), .COMP_LATENCY(CL)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .pause_i     (pause),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_data_i  (req_data),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .comp_init_o (comp_init),
    .comp_data_o (comp_data),
    .comp_done_i (comp_done),
    .comp_data_i (comp_rdat),
    .busy_o      (busy),
    .err_o       (err)
  );

  function automatic logic [W-1:0] num(input logic [3:0][W-1:0] o);
    return o[M_IDX] * o[D_IDX] - o[L_IDX] * o[C_IDX];
  endfunction

  // Compute unit stand-in with fixed latency CL, sharing the reset
  logic         cu_v [CL];
  logic [W-1:0] cu_r [CL];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CL; k++) begin cu_v[k] <= 1'b0; cu_r[k] <= '0; end
    end else begin
      for (int k = CL - 1; k > 0; k--) begin cu_v[k] <= cu_v[k-1]; cu_r[k] <= cu_r[k-1]; end
      cu_v[0] <= comp_init;
      cu_r[0] <= num(comp_data);
    end
  end
  assign comp_done = cu_v[CL-1] | inj_done;
  assign comp_rdat = cu_r[CL-1];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: pointer, expected responses keyed by due cycle
  typedef struct {
    int           due;
    int           id;
    logic [W-1:0] val;
  } exp_t;
  exp_t              q[$];
  int                mptr = 0;
  int                cyc = 0;
  logic              prev_fire = 1'b0;
  logic [3:0][W-1:0] prev_data = '0;
  logic              err_exp = 1'b0;
  logic [N-1:0]      last_fire = '0;

  task automatic step(input logic [N-1:0] v, input logic p, input logic use_tbl, input logic [N-1:0] tbl_rdy);
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rv;
    logic [W-1:0] exp_rd;
    int           g;
    @(negedge clk);
    req_valid = v;
    pause     = p;
    #1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && v[(mptr + k) % N]) g = (mptr + k) % N;
    end
    exp_rdy = '0;
    if (!p && g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", W'(req_ready), W'(exp_rdy));
    if (use_tbl) chk("req_ready_table", W'(req_ready), W'(tbl_rdy));
    chk("comp_init", W'(comp_init), W'(prev_fire));
    chk("comp_data_M", comp_data[M_IDX], prev_data[M_IDX]);
    chk("comp_data_C", comp_data[C_IDX], prev_data[C_IDX]);
    chk("busy", W'(busy), W'(q.size() != 0));
    exp_rv = '0;
    exp_rd = '0;
    if (q.size() != 0 && q[0].due == cyc) begin
      exp_rv[q[0].id] = 1'b1;
      exp_rd = q[0].val;
      void'(q.pop_front());
    end
    chk("rsp_valid", W'(rsp_valid), W'(exp_rv));
    chk("rsp_data", rsp_data, exp_rd);
    chk("err", W'(err), W'(err_exp));
    last_fire = exp_rdy;
    prev_fire = |exp_rdy;
    prev_data = '0;
    if (|exp_rdy) begin
      q.push_back('{due: cyc + CL + 2, id: g, val: num(req_data[g])});
      prev_data = req_data[g];
      mptr = (g + 1) % N;
    end
    cyc++;
    @(posedge clk);
  endtask

  typedef struct {
    logic [N-1:0] vld;
    logic         pause;
    logic [N-1:0] rdy;
  } vec_t;
  vec_t tbl[$];

  logic [N-1:0] hold;

  initial begin
    // Reset state
    #7;
    chk("rst_ready", W'(req_ready), '0);
    chk("rst_rsp_valid", W'(rsp_valid), '0);
    chk("rst_comp_init", W'(comp_init), '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_err", W'(err), '0);
    @(negedge clk);
    rst_n = 1'b1;

    req_data[0] = {64'd3, 64'd4, 64'd1, 64'd2};
    req_data[1] = {64'd5, 64'd6, 64'd7, 64'd8};
    req_data[2] = {64'd0, 64'd0, 64'd1, 64'd1};
    req_data[3] = {64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3};

    // Req0 alone: result 10 lands three cycles after the handshake
    step(4'b0001, 1'b0, 1'b1, 4'b0001);
    step(4'b0000, 1'b0, 1'b0, '0);
    step(4'b0000, 1'b0, 1'b0, '0);
    #2;
    chk("req0_rsp_valid", W'(rsp_valid), W'(4'b0001));
    chk("req0_rsp_data", rsp_data, 64'd10);
    step(4'b0000, 1'b0, 1'b0, '0);

    // Req2: 0*0 - 1*1 wraps to all ones
    step(4'b0100, 1'b0, 1'b1, 4'b0100);
    step(4'b0000, 1'b0, 1'b0, '0);
    step(4'b0000, 1'b0, 1'b0, '0);
    #2;
    chk("req2_rsp_valid", W'(rsp_valid), W'(4'b0100));
    chk("req2_rsp_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);
    step(4'b0000, 1'b0, 1'b0, '0);

    // Directed table; pointer is 3 here
    tbl.push_back('{4'b1000, 1'b0, 4'b1000});
    for (int r = 0; r < 2; r++) begin
      tbl.push_back('{4'b1111, 1'b0, 4'b0001});
      tbl.push_back('{4'b1111, 1'b0, 4'b0010});
      tbl.push_back('{4'b1111, 1'b0, 4'b0100});
      tbl.push_back('{4'b1111, 1'b0, 4'b1000});
    end
    tbl.push_back('{4'b0000, 1'b0, 4'b0000});
    tbl.push_back('{4'b0010, 1'b0, 4'b0010});
    tbl.push_back('{4'b1010, 1'b0, 4'b1000});
    tbl.push_back('{4'b1010, 1'b0, 4'b0010});
    for (int r = 0; r < 3; r++) tbl.push_back('{4'b1010, 1'b1, 4'b0000});
    tbl.push_back('{4'b1010, 1'b0, 4'b1000});
    tbl.push_back('{4'b0010, 1'b0, 4'b0010});
    tbl.push_back('{4'b1000, 1'b0, 4'b1000});
    for (int r = 0; r < 4; r++) tbl.push_back('{4'b0000, 1'b0, 4'b0000});
    foreach (tbl[i]) step(tbl[i].vld, tbl[i].pause, 1'b1, tbl[i].rdy);

    // Spurious done with nothing outstanding: sticky error, no response
    #1 inj_done = 1'b1;
    step(4'b0000, 1'b0, 1'b0, '0);
    #1 inj_done = 1'b0;
    err_exp = 1'b1;
    step(4'b0000, 1'b0, 1'b0, '0);
    step(4'b0000, 1'b0, 1'b0, '0);

    // Reset between issue and done
    step(4'b0010, 1'b0, 1'b1, 4'b0010);
    step(4'b0000, 1'b0, 1'b0, '0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_comp_init", W'(comp_init), '0);
    chk("arst_comp_data", comp_data[M_IDX] | comp_data[D_IDX], '0);
    chk("arst_rsp_valid", W'(rsp_valid), '0);
    chk("arst_rsp_data", rsp_data, '0);
    chk("arst_busy", W'(busy), '0);
    chk("arst_err", W'(err), '0);
    q.delete();
    mptr = 0; prev_fire = 1'b0; prev_data = '0; err_exp = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) step(4'b0000, 1'b0, 1'b0, '0);
    step(4'b0101, 1'b0, 1'b1, 4'b0001);
    step(4'b0000, 1'b0, 1'b0, '0);
    step(4'b0000, 1'b0, 1'b0, '0);
    #2;
    chk("post_rst_rsp_valid", W'(rsp_valid), W'(4'b0001));
    chk("post_rst_rsp_data", rsp_data, 64'd10);
    step(4'b0000, 1'b0, 1'b0, '0);

    // Random traffic; requests hold valid and data until accepted
    hold = '0;
    for (int c = 0; c < 400; c++) begin
      #1;
      for (int i = 0; i < N; i++) begin
        if (!hold[i] && $urandom_range(0, 2) == 0) begin
          hold[i] = 1'b1;
          for (int j = 0; j < 4; j++)
            req_data[i][j] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 9))
                                                         : {$urandom, $urandom};
        end
      end
      step(hold, ($urandom_range(0, 5) == 0), 1'b0, '0);
      hold = hold & ~last_fire;
    end
    for (int r = 0; r < 6; r++) step(4'b0000, 1'b0, 1'b0, '0);
    chk("drain_queue_empty", W'(q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
